// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Definitions shared by the CNN front end (row_assembler) and cnn_layer:
//   IMG_WIDTH / IMG_HEIGHT : default image geometry in pixels
//   VALUE_BITS             : default width of one pixel channel value
//   row_occ_e              : occupancy of the two-row ping-pong buffer
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int IMG_WIDTH  = 28;
    localparam int IMG_HEIGHT = 28;
    localparam int VALUE_BITS = 8;

    // Completed rows that are waiting for the consumer to take them.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } row_occ_e;

endpackage : cnn_pkg

// File: rtl/row_buffer.sv
// -----------------------------------------------------------------------------
// row_buffer
// One row of pixel values stored in registers. A single value is written per
// cycle at (wr_col_i, wr_ch_i) when wr_en_i is high; the whole row is always
// visible on row_o.
//   clock_i   : clock, posedge
//   wr_en_i   : load enable for the addressed entry
//   wr_col_i  : column of the entry to write
//   wr_ch_i   : channel of the entry to write
//   wr_data_i : value to write
//   row_o     : stored row, indexed [column][channel]
// -----------------------------------------------------------------------------
module row_buffer #(
    parameter int WIDTH        = 28,
    parameter int NUM_CHANNELS = 1,
    parameter int VALUE_BITS   = 8,
    parameter int COL_W        = 5,
    parameter int CH_W         = 1
) (
    input  logic                                             clock_i,
    input  logic                                             wr_en_i,
    input  logic [COL_W-1:0]                                 wr_col_i,
    input  logic [CH_W-1:0]                                  wr_ch_i,
    input  logic [VALUE_BITS-1:0]                            wr_data_i,
    output logic [WIDTH-1:0][NUM_CHANNELS-1:0][VALUE_BITS-1:0] row_o
);

    // NOTE: the row storage has no reset; its contents are only observed once
    // a full row has been written, so clearing it would buy nothing.
    always_ff @(posedge clock_i) begin
        for (int c = 0; c < WIDTH; c++) begin
            for (int h = 0; h < NUM_CHANNELS; h++) begin
                // NOTE: clocked state is written with non-blocking assignments
                // so every register samples pre-edge values.
                if (wr_en_i && (wr_col_i == COL_W'(c)) && (wr_ch_i == CH_W'(h))) begin
                    row_o[c][h] <= wr_data_i;
                end
            end
        end
    end

endmodule : row_buffer

// File: rtl/row_assembler.sv
// -----------------------------------------------------------------------------
// row_assembler
// Collects a stream of channel values (channel fastest, then column, then row)
// into complete rows and hands each row to the consumer through a
// valid/ready handshake. Two row buffers ping-pong: one fills while the other
// is presented. When both hold unaccepted rows the input is stalled.
//   clock_i          : clock, posedge
//   reset_i          : synchronous reset, active low
//   in_data_i        : one channel value, unsigned, saturated to VALUE_BITS
//   in_valid_i       : in_data_i holds a value
//   upstream_stall_o : input transfer is not taken while high
//   out_row_o        : presented row, indexed [column][channel]
//   out_row_valid_o  : out_row_o holds a completed row
//   out_row_ready_i  : consumer accepts the presented row
//   out_last_row_o   : presented row is the last row of its image
// -----------------------------------------------------------------------------
module row_assembler #(
    parameter int WIDTH        = cnn_pkg::IMG_WIDTH,
    parameter int HEIGHT       = cnn_pkg::IMG_HEIGHT,
    parameter int VALUE_BITS   = cnn_pkg::VALUE_BITS,
    parameter int NUM_CHANNELS = 1
) (
    input  logic                                               clock_i,
    input  logic                                               reset_i,
    input  logic [31:0]                                        in_data_i,
    input  logic                                               in_valid_i,
    output logic                                               upstream_stall_o,
    output logic [WIDTH-1:0][NUM_CHANNELS-1:0][VALUE_BITS-1:0] out_row_o,
    output logic                                               out_row_valid_o,
    input  logic                                               out_row_ready_i,
    output logic                                               out_last_row_o
);

    import cnn_pkg::*;

    localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CHANNELS - 1);

    // Largest representable output value, computed wide so VALUE_BITS=32 works.
    localparam logic [31:0] MAX_VALUE = 32'((64'd1 << VALUE_BITS) - 64'd1);

    row_occ_e         state;
    logic [COL_W-1:0] col_cnt;
    logic [ROW_W-1:0] row_cnt;
    logic [CH_W-1:0]  ch_cnt;
    logic             fill_sel;   // buffer receiving input values
    logic             pres_sel;   // buffer driven onto out_row_o
    logic [1:0]       row_last;   // last-row flag captured per buffer

    logic [WIDTH-1:0][NUM_CHANNELS-1:0][VALUE_BITS-1:0] row_q [2];

    logic                  take;
    logic                  row_done;
    logic                  accept;
    logic [VALUE_BITS-1:0] sat_value;

    assign take      = in_valid_i && !upstream_stall_o;
    assign row_done  = take && (ch_cnt == CH_LAST) && (col_cnt == COL_LAST);
    assign accept    = out_row_valid_o && out_row_ready_i;
    assign sat_value = (in_data_i > MAX_VALUE) ? '1 : in_data_i[VALUE_BITS-1:0];

    for (genvar b = 0; b < 2; b++) begin : g_buf
        row_buffer #(
            .WIDTH        (WIDTH),
            .NUM_CHANNELS (NUM_CHANNELS),
            .VALUE_BITS   (VALUE_BITS),
            .COL_W        (COL_W),
            .CH_W         (CH_W)
        ) u_row_buffer (
            .clock_i   (clock_i),
            .wr_en_i   (take && (fill_sel == 1'(b))),
            .wr_col_i  (col_cnt),
            .wr_ch_i   (ch_cnt),
            .wr_data_i (sat_value),
            .row_o     (row_q[b])
        );
    end

    assign out_row_o      = row_q[pres_sel];
    assign out_last_row_o = out_row_valid_o && row_last[pres_sel];

    // Position counters: channel fastest, then column, then row (wrapping).
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            ch_cnt  <= '0;
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (take) begin
            if (ch_cnt == CH_LAST) begin
                ch_cnt <= '0;
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end else begin
                ch_cnt <= ch_cnt + 1'b1;
            end
        end
    end

    // Occupancy FSM. Every completion hands the fill buffer over (fill_sel
    // flips) and every accept moves presentation to the other buffer
    // (pres_sel flips); in EMPTY both selects coincide, so a completion there
    // presents exactly the buffer that was just filled.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            state            <= EMPTY;
            out_row_valid_o  <= 1'b0;
            upstream_stall_o <= 1'b0;
            fill_sel         <= 1'b0;
            pres_sel         <= 1'b0;
            row_last         <= '0;
        end else begin
            if (row_done) begin
                fill_sel           <= ~fill_sel;
                row_last[fill_sel] <= (row_cnt == ROW_LAST);
            end
            if (accept) begin
                pres_sel <= ~pres_sel;
            end

            case (state)
                EMPTY: begin
                    if (row_done) begin
                        state           <= ONE;
                        out_row_valid_o <= 1'b1;
                    end
                end
                ONE: begin
                    if (row_done && !accept) begin
                        state            <= TWO;
                        upstream_stall_o <= 1'b1;
                    end else if (accept && !row_done) begin
                        state           <= EMPTY;
                        out_row_valid_o <= 1'b0;
                    end
                end
                TWO: begin
                    // Input is stalled here, so no completion can coincide.
                    if (accept) begin
                        state            <= ONE;
                        upstream_stall_o <= 1'b0;
                    end
                end
                default: begin
                    state            <= EMPTY;
                    out_row_valid_o  <= 1'b0;
                    upstream_stall_o <= 1'b0;
                end
            endcase
        end
    end

endmodule : row_assembler

// File: doc/row_assembler.md
ROW_ASSEMBLER -- requirements
Module: row_assembler

Interface
REQ-001 SHALL have parameter WIDTH, default 28: pixels (columns) per row.
REQ-002 SHALL have parameter HEIGHT, default 28: rows per image.
REQ-003 SHALL have parameter VALUE_BITS, default 8: bits per output pixel value.
REQ-004 SHALL have parameter NUM_CHANNELS, default 1: channel values per pixel.
REQ-005 SHALL have port clock_i  in  1: single clock, all logic on posedge.
REQ-006 SHALL have port reset_i  in  1: reset, synchronous, active-low.
REQ-007 SHALL have port in_data_i  in  32: one channel value per transfer, unsigned.
REQ-008 SHALL have port in_valid_i  in  1: in_data_i holds a value.
REQ-009 SHALL have port upstream_stall_o  out  1: when high, the input transfer is not taken.
REQ-010 SHALL have port out_row_o  out  [WIDTH][NUM_CHANNELS] x VALUE_BITS: the completed row.
REQ-011 SHALL have port out_row_valid_o  out  1: out_row_o holds a completed row.
REQ-012 SHALL have port out_row_ready_i  in  1: the downstream cnn_layer accepts the row.
REQ-013 SHALL have port out_last_row_o  out  1: the presented row is row HEIGHT-1 of its image.

Function
REQ-014 SHALL take an input transfer on a cycle with in_valid_i=1 and upstream_stall_o=0; all other cycles SHALL leave state unchanged.
REQ-015 SHALL receive input order channel-fastest, then column 0..WIDTH-1, then row 0..HEIGHT-1.
REQ-016 SHALL saturate each value: in_data_i > 2^VALUE_BITS-1 gives all-ones, otherwise the low VALUE_BITS bits.
REQ-017 SHALL keep counters ch_cnt (0..NUM_CHANNELS-1), col_cnt (0..WIDTH-1) and row_cnt (0..HEIGHT-1), advancing per taken transfer with carry; row_cnt SHALL wrap HEIGHT-1 -> 0.
REQ-018 SHALL use two row buffers (ping-pong): one fill buffer and one present buffer.
REQ-019 SHALL track occupancy with FSM states EMPTY, ONE and TWO, counting completed rows not yet accepted.
REQ-020 SHALL make a row complete on the cycle its final value (col WIDTH-1, ch NUM_CHANNELS-1) is taken.
REQ-021 SHALL assert out_row_valid_o on the cycle after completion (latency 1), with out_row_o stable until accepted.
REQ-022 SHALL treat out_row_valid_o && out_row_ready_i as acceptance of the presented row.
REQ-023 FSM transitions: a completion alone moves the state up by one; an accept alone moves it down by one; completion and accept in the same cycle leave the state unchanged and swap the buffer roles.
REQ-024 SHALL set upstream_stall_o = (state==TWO), registered, with no combinational path from out_row_ready_i.
REQ-025 In state TWO with an accept, upstream_stall_o SHALL deassert on the next cycle.
REQ-026 SHALL present rows strictly in completion order; no row is dropped or duplicated.
REQ-027 SHALL set out_last_row_o to the row_cnt value captured with the row (==HEIGHT-1), held stable with out_row_o.
REQ-028 SHALL keep out_row_valid_o high while unaccepted, with no retraction before acceptance.

Reset
REQ-029 With reset_i=0 at a posedge: state EMPTY, all counters 0, out_row_valid_o=0, out_last_row_o=0, upstream_stall_o=0; buffer contents are don't-care.
REQ-030 Reset mid-row or mid-image SHALL discard partial and pending rows; the first transfer after reset is row 0, col 0, ch 0.
REQ-031 SHALL ignore in_valid_i and out_row_ready_i during reset.

Structure
REQ-032 SHALL take IMG_WIDTH=28, IMG_HEIGHT=28 and VALUE_BITS=8 defaults, plus the row_occ_e FSM enum, from shared package cnn_pkg, which cnn_layer also uses.
REQ-033 SHALL implement each ping-pong buffer as an instance of sub-module row_buffer (a write-indexed register row with a load enable); counters and FSM stay in row_assembler.

Verification (WIDTH=4, HEIGHT=3, VALUE_BITS=8, NUM_CHANNELS=1)
REQ-034 Stream 1,2,3,4 with ready=1 -> out_row_o={1,2,3,4} valid on the cycle after the 4th transfer, last_row=0.
REQ-035 Stream 300, 255, 0, 70000 -> row {255,255,0,255}.
REQ-036 Hold ready=0 and stream 12 values -> stall rises after the 8th value, row {1..4} is held, and the 9th value is not taken until an accept; values 9..12 then complete row 3.
REQ-037 Completion and accept in the same cycle (state ONE) -> state stays ONE, the next row is presented the following cycle, and stall stays 0.
REQ-038 A full image of 12 values -> the third row has last_row=1, and the next value starts row 0 (last_row=0).
REQ-039 Reset_i=0 after 2 values of a row, then stream 5,6,7,8 -> first row out = {5,6,7,8}, and valid stays 0 during reset.
